// File: rtl/cpu_operand_fetch_pkg.sv
// Shared types and constants for the operand-fetch block: FSM states,
// datapath widths and the effective-address helper for the half regfile.
package cpu_operand_fetch_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAP1 = 2'd1,
    CAP2 = 2'd2,
    RSP  = 2'd3
  } opf_state_e;

  // The 16-register build reads with the low four address bits only.
  function automatic logic [REG_ADDR_W-1:0] eff_addr(
    input logic [REG_ADDR_W-1:0] addr,
    input logic                  half
  );
    return half ? {1'b0, addr[REG_ADDR_W-2:0]} : addr;
  endfunction

endpackage

// File: rtl/cpu_opfetch_bypass.sv
// Writeback snoop for one operand: flags an address match against the
// writeback port and substitutes the written value for the current one.
module cpu_opfetch_bypass
  import cpu_operand_fetch_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  input  logic [XLEN-1:0]       cur_data,
  output logic                  hit,
  output logic [XLEN-1:0]       data
);

  assign hit  = wb_en && (wb_addr != REG_ZERO) && (wb_addr == addr);
  assign data = hit ? wb_data : cur_data;

endmodule

// File: rtl/cpu_operand_fetch.sv
// Operand fetch: sequences rs1/rs2 reads through a single registered regfile
// read port. Define CPU_OPFETCH_BYPASS_EN to snoop writeback into held operands.
module cpu_operand_fetch
  import cpu_operand_fetch_pkg::*;
#(
  parameter bit P_HALF_REGFILE = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  input  logic                  i_use_rs2,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [XLEN-1:0]       o_rs1_data,
  output logic [XLEN-1:0]       o_rs2_data,
  output logic                  o_rsp_oob,
  output logic [REG_ADDR_W-1:0] o_rf_rd_addr,
  input  logic [XLEN-1:0]       i_rf_rd_data,
  input  logic                  i_rf_busy,
  input  logic                  i_wb_en,
  input  logic [REG_ADDR_W-1:0] i_wb_addr,
  input  logic [XLEN-1:0]       i_wb_data
);

  opf_state_e            state_q, state_d;
  logic [REG_ADDR_W-1:0] rs1_addr_q, rs2_addr_q;
  logic                  use_rs2_q, oob_q;
  logic [XLEN-1:0]       rs1_data_q, rs2_data_q;
  // Writeback seen in the address-issue cycle, applied at capture.
  logic                  pend1_q, pend2_q;
  logic [XLEN-1:0]       pend1_data_q, pend2_data_q;

  logic [REG_ADDR_W-1:0] rs1_eff, rs2_eff, byp1_addr;
  logic                  accept, oob_d;
  logic [XLEN-1:0]       cand1, cand2;
  logic                  byp1_hit, byp2_hit;
  logic [XLEN-1:0]       byp1_data, byp2_data;

  assign rs1_eff = eff_addr(i_rs1_addr, P_HALF_REGFILE);
  assign rs2_eff = eff_addr(i_rs2_addr, P_HALF_REGFILE);
  assign oob_d   = P_HALF_REGFILE &&
                   (i_rs1_addr[REG_ADDR_W-1] || (i_use_rs2 && i_rs2_addr[REG_ADDR_W-1]));

  assign o_req_ready  = i_rst_n && (state_q == IDLE) && !i_rf_busy && !i_flush;
  assign accept       = i_req_valid && o_req_ready;
  assign o_rsp_valid  = (state_q == RSP) && !i_flush;
  assign o_rs1_data   = rs1_data_q;
  assign o_rs2_data   = rs2_data_q;
  assign o_rsp_oob    = oob_q;
  assign o_rf_rd_addr = (state_q == IDLE) ? rs1_eff : rs2_addr_q;

  // Candidate operand value before any writeback substitution.
  assign byp1_addr = (state_q == IDLE) ? rs1_eff : rs1_addr_q;
  assign cand1     = (state_q == CAP1) ? (pend1_q ? pend1_data_q : i_rf_rd_data) : rs1_data_q;
  assign cand2     = (state_q == CAP2) ? (pend2_q ? pend2_data_q : i_rf_rd_data) : rs2_data_q;

`ifdef CPU_OPFETCH_BYPASS_EN
  cpu_opfetch_bypass u_byp_rs1 (
    .addr     (byp1_addr),
    .wb_en    (i_wb_en),
    .wb_addr  (i_wb_addr),
    .wb_data  (i_wb_data),
    .cur_data (cand1),
    .hit      (byp1_hit),
    .data     (byp1_data)
  );

  cpu_opfetch_bypass u_byp_rs2 (
    .addr     (rs2_addr_q),
    .wb_en    (i_wb_en),
    .wb_addr  (i_wb_addr),
    .wb_data  (i_wb_data),
    .cur_data (cand2),
    .hit      (byp2_hit),
    .data     (byp2_data)
  );
`else
  logic unused_snoop;
  assign unused_snoop = ^{i_wb_en, i_wb_addr, byp1_addr};
  assign byp1_hit     = 1'b0;
  assign byp2_hit     = 1'b0;
  assign byp1_data    = cand1;
  assign byp2_data    = cand2;
`endif

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CAP1;
      CAP1:    state_d = use_rs2_q ? CAP2 : RSP;
      CAP2:    state_d = RSP;
      RSP:     if (i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_flush) state_d = IDLE;
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rs1_addr_q   <= REG_ZERO;
      rs2_addr_q   <= REG_ZERO;
      use_rs2_q    <= 1'b0;
      oob_q        <= 1'b0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      pend1_q      <= 1'b0;
      pend2_q      <= 1'b0;
      pend1_data_q <= '0;
      pend2_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            rs1_addr_q   <= rs1_eff;
            rs2_addr_q   <= rs2_eff;
            use_rs2_q    <= i_use_rs2;
            oob_q        <= oob_d;
            pend1_q      <= byp1_hit;
            pend1_data_q <= i_wb_data;
          end
        end
        CAP1: begin
          rs1_data_q   <= (rs1_addr_q == REG_ZERO) ? '0 : byp1_data;
          rs2_data_q   <= '0;
          pend2_q      <= use_rs2_q && byp2_hit;
          pend2_data_q <= i_wb_data;
        end
        CAP2: begin
          rs1_data_q <= byp1_data;
          rs2_data_q <= (rs2_addr_q == REG_ZERO) ? '0 : byp2_data;
        end
        RSP: begin
          rs1_data_q <= byp1_data;
          if (use_rs2_q) rs2_data_q <= byp2_data;
        end
        default: ;
      endcase
    end
  end

endmodule
